// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control decoder and the iterative mul/div unit.
package alu_pkg;

    // ALUOp classes coming from the main decoder
    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    // Funct7 values that select instruction variants
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // ALU Operation encodings
    localparam logic [3:0] OP_AND     = 4'b0000;
    localparam logic [3:0] OP_OR      = 4'b0001;
    localparam logic [3:0] OP_ADD     = 4'b0010;
    localparam logic [3:0] OP_XOR     = 4'b0011;
    localparam logic [3:0] OP_SUB     = 4'b0100;
    localparam logic [3:0] OP_SLT     = 4'b0101;
    localparam logic [3:0] OP_SLL     = 4'b0110;
    localparam logic [3:0] OP_SRL     = 4'b0111;
    localparam logic [3:0] OP_BEQ     = 4'b1000;
    localparam logic [3:0] OP_SRA     = 4'b1001;
    localparam logic [3:0] OP_BGE     = 4'b1010;
    localparam logic [3:0] OP_BNE     = 4'b1100;
    localparam logic [3:0] OP_MD_PASS = 4'b1111;

    // M-extension Funct3 codes
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Mul/div sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring-divide bit per step.
// Operands are converted to magnitudes at load; the sign is applied to the final value.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            step_i,
    input  logic            clr_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            last_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);

    logic [2*XLEN-1:0] p_q, p_d;
    logic [XLEN-1:0]   b_q;
    logic [2:0]        f3_q;
    logic              neg_q;
    logic [CW-1:0]     cnt_q;

    logic              a_sgn, b_sgn, a_neg, b_neg, neg_d;
    logic [XLEN-1:0]   a_mag, b_mag;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     shifted;
    logic              ge;
    logic [XLEN-1:0]   r_new;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo_rem;

    // MUL only needs the low half, which is sign-agnostic, so it runs unsigned
    assign a_sgn = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                   (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
    assign b_sgn = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) || (funct3_i == F3_REM);
    assign a_neg = a_sgn & rs1_i[XLEN-1];
    assign b_neg = b_sgn & rs2_i[XLEN-1];
    assign a_mag = a_neg ? -rs1_i : rs1_i;
    assign b_mag = b_neg ? -rs2_i : rs2_i;
    // Remainder takes the dividend's sign; products and quotients take the xor
    assign neg_d = (funct3_i[2] && funct3_i[1]) ? a_neg : (a_neg ^ b_neg);

    // One iteration step; p_q holds {hi, lo} for multiply or {remainder, quotient} for divide
    always_comb begin
        p_d     = p_q;
        mul_sum = '0;
        shifted = '0;
        ge      = 1'b0;
        r_new   = '0;
        if (!f3_q[2]) begin
            mul_sum = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, b_q} : '0);
            p_d     = {mul_sum, p_q[XLEN-1:1]};
        end else begin
            shifted = p_q[2*XLEN-1:XLEN-1];
            ge      = (shifted >= {1'b0, b_q});
            r_new   = ge ? (shifted[XLEN-1:0] - b_q) : shifted[XLEN-1:0];
            p_d     = {r_new, p_q[XLEN-2:0], ge};
        end
    end

    // Signed result of the value the current step produces (valid on the last step)
    always_comb begin
        prod    = neg_q ? -p_d : p_d;
        quo_rem = f3_q[1] ? p_d[2*XLEN-1:XLEN] : p_d[XLEN-1:0];
        if (!f3_q[2]) result_o = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else          result_o = neg_q ? -quo_rem : quo_rem;
    end

    assign last_o = (cnt_q == CW'(XLEN-1));

    // Operand load, iteration register and step counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= '0;
            b_q   <= '0;
            f3_q  <= '0;
            neg_q <= 1'b0;
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (start_i) begin
            p_q   <= {{XLEN{1'b0}}, a_mag};
            b_q   <= b_mag;
            f3_q  <= funct3_i;
            neg_q <= neg_d;
            cnt_q <= '0;
        end else if (step_i) begin
            p_q   <= p_d;
            cnt_q <= last_o ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_mdu_controller.sv
// ALU control decoder plus IDLE/BUSY/DONE sequencer for the iterative mul/div unit.
module alu_mdu_controller
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OPW  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [OPW-1:0]  Operation,
    output logic            illegal,
    output logic            stall,
    output logic            md_valid,
    output logic [XLEN-1:0] md_result
);

    md_state_e       state_q;
    logic            md_valid_q;
    logic [XLEN-1:0] md_result_q;

    logic [3:0]      op_c;
    logic            ill_c;
    logic            is_m, accept, div_zero, ovf, special;
    logic [XLEN-1:0] special_res;
    logic            mdu_last;
    logic [XLEN-1:0] mdu_res;

    // Operation decode; anything not explicitly legal falls to AND with illegal set
    always_comb begin
        op_c  = OP_AND;
        ill_c = 1'b1;
        unique case (ALUOp)
            ALUOP_MEM: begin op_c = OP_ADD; ill_c = 1'b0; end
            ALUOP_BR: begin
                ill_c = 1'b0;
                case (Funct3)
                    3'b000:  op_c = OP_BEQ;
                    3'b001:  op_c = OP_BNE;
                    3'b100:  op_c = OP_SLT;
                    3'b101:  op_c = OP_BGE;
                    default: ill_c = 1'b1;
                endcase
            end
            ALUOP_R: begin
                if (Funct7 == F7_MULDIV) begin
                    op_c = OP_MD_PASS; ill_c = 1'b0;
                end else if (Funct7 == F7_BASE) begin
                    ill_c = 1'b0;
                    case (Funct3)
                        3'b000:  op_c = OP_ADD;
                        3'b010:  op_c = OP_SLT;
                        3'b100:  op_c = OP_XOR;
                        3'b110:  op_c = OP_OR;
                        3'b111:  op_c = OP_AND;
                        default: ill_c = 1'b1;
                    endcase
                end else if (Funct7 == F7_ALT && Funct3 == 3'b000) begin
                    op_c = OP_SUB; ill_c = 1'b0;
                end
            end
            ALUOP_I: begin
                // ADDI/SLTI carry immediate bits in Funct7, so it is not checked there
                ill_c = 1'b0;
                case (Funct3)
                    3'b000: op_c = OP_ADD;
                    3'b010: op_c = OP_SLT;
                    3'b001: if (Funct7 == F7_BASE) op_c = OP_SLL; else ill_c = 1'b1;
                    3'b101: begin
                        if      (Funct7 == F7_BASE) op_c = OP_SRL;
                        else if (Funct7 == F7_ALT)  op_c = OP_SRA;
                        else                        ill_c = 1'b1;
                    end
                    default: ill_c = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    assign Operation = OPW'(op_c);
    assign illegal   = ill_c;

    // Acceptance and the two corner cases that finish without iterating
    assign is_m     = (ALUOp == ALUOP_R) && (Funct7 == F7_MULDIV);
    assign accept   = (state_q == S_IDLE) && in_valid && is_m && !flush;
    assign div_zero = Funct3[2] && (rs2_data == '0);
    assign ovf      = ((Funct3 == F3_DIV) || (Funct3 == F3_REM)) &&
                      (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    assign special  = div_zero || ovf;
    assign special_res = div_zero ? (Funct3[1] ? rs1_data : '1)
                                  : (Funct3[1] ? '0 : rs1_data);

    assign stall     = accept || (state_q == S_BUSY);
    assign md_valid  = md_valid_q && !flush;
    assign md_result = md_result_q;

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (accept && !special),
        .step_i   ((state_q == S_BUSY) && !flush),
        .clr_i    (flush),
        .funct3_i (Funct3),
        .rs1_i    (rs1_data),
        .rs2_i    (rs2_data),
        .last_o   (mdu_last),
        .result_o (mdu_res)
    );

    // Sequencer: flush wins over everything, DONE lasts exactly one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            md_valid_q  <= 1'b0;
            md_result_q <= '0;
        end else begin
            md_valid_q <= 1'b0;
            if (flush) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (accept) begin
                            if (special) begin
                                state_q     <= S_DONE;
                                md_valid_q  <= 1'b1;
                                md_result_q <= special_res;
                            end else begin
                                state_q <= S_BUSY;
                            end
                        end
                    end
                    S_BUSY: begin
                        if (mdu_last) begin
                            state_q     <= S_DONE;
                            md_valid_q  <= 1'b1;
                            md_result_q <= mdu_res;
                        end
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_mdu_controller.sv
// Self-checking bench for alu_mdu_controller (XLEN=32): decode sweep, directed and
// randomized mul/div against a 64-bit arithmetic reference, flush and reset aborts.
module tb_alu_mdu_controller;

    localparam int XLEN = 32;
    localparam int OPW  = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      ALUOp;
    logic [6:0]      Funct7;
    logic [2:0]      Funct3;
    logic            in_valid, flush;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic [OPW-1:0]  Operation;
    logic            illegal, stall, md_valid;
    logic [XLEN-1:0] md_result;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_res = '0;

    alu_mdu_controller #(.XLEN(XLEN), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
        .in_valid(in_valid), .flush(flush), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .Operation(Operation), .illegal(illegal), .stall(stall),
        .md_valid(md_valid), .md_result(md_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode, written from the instruction tables
    function automatic void ref_dec(input int aop, input int f3, input int f7,
                                    output logic [3:0] op, output logic ill);
        logic [3:0] r_ops [8] = '{4'b0010, 4'b0000, 4'b0101, 4'b0000,
                                  4'b0011, 4'b0000, 4'b0001, 4'b0000};
        bit         r_ok  [8] = '{1, 0, 1, 0, 1, 0, 1, 1};
        op = 4'b0000; ill = 1'b1;
        if (aop == 0) begin
            op = 4'b0010; ill = 1'b0;
        end else if (aop == 1) begin
            ill = 1'b0;
            if      (f3 == 0) op = 4'b1000;
            else if (f3 == 1) op = 4'b1100;
            else if (f3 == 4) op = 4'b0101;
            else if (f3 == 5) op = 4'b1010;
            else              ill = 1'b1;
        end else if (aop == 2) begin
            if (f7 == 1)                      begin op = 4'b1111;   ill = 1'b0; end
            else if (f7 == 0 && r_ok[f3])     begin op = r_ops[f3]; ill = 1'b0; end
            else if (f7 == 32 && f3 == 0)     begin op = 4'b0100;   ill = 1'b0; end
        end else begin
            if      (f3 == 0)             begin op = 4'b0010; ill = 1'b0; end
            else if (f3 == 2)             begin op = 4'b0101; ill = 1'b0; end
            else if (f3 == 1 && f7 == 0)  begin op = 4'b0110; ill = 1'b0; end
            else if (f3 == 5 && f7 == 0)  begin op = 4'b0111; ill = 1'b0; end
            else if (f3 == 5 && f7 == 32) begin op = 4'b1001; ill = 1'b0; end
        end
    endfunction

    // Reference mul/div using plain 64-bit arithmetic
    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        logic [63:0] p;
        bit ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Present one M op and follow it to md_valid; noisy keeps offering other M ops
    task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input bit noisy, input string tag);
        int lat;
        bit seen;
        int exp_l;
        logic [31:0] exp_r;
        exp_r = ref_md(f3, a, b);
        exp_l = (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
                ? 1 : XLEN + 1;
        @(negedge clk);
        ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = f3; rs1_data = a; rs2_data = b; in_valid = 1'b1;
        #1;
        chk({tag, "/accept_stall"}, stall, 1);
        chk({tag, "/op"}, Operation, 4'b1111);
        lat = 0; seen = 0;
        while (!seen && lat < 80) begin
            @(negedge clk);
            lat++;
            if (md_valid) begin
                seen = 1;
                chk({tag, "/latency"}, lat, exp_l);
                chk({tag, "/result"}, md_result, exp_r);
                chk({tag, "/done_stall"}, stall, 0);
            end else if (lat < exp_l) begin
                chk({tag, "/busy_stall"}, stall, 1);
            end
            if (noisy) begin
                Funct3 = 3'($urandom_range(0, 7)); rs1_data = $urandom; rs2_data = $urandom;
            end
            if (seen) in_valid = 1'b0;
        end
        chk({tag, "/seen"}, seen, 1);
        @(negedge clk);
        chk({tag, "/single_pulse"}, md_valid, 0);
        chk({tag, "/idle_stall"}, stall, 0);
        chk({tag, "/hold"}, md_result, exp_r);
        last_res = exp_r;
    endtask

    // Start a MUL, abort it at BUSY cycle 10 with flush or reset
    task automatic abort_at10(input bit use_reset, input string tag);
        bit any;
        @(negedge clk);
        ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = 3'd0; rs1_data = 32'd7;
        rs2_data = 32'hFFFF_FFFD; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk({tag, "/busy10_stall"}, stall, 1);
        if (use_reset) begin
            rst_n = 1'b0;
            #1;
            chk({tag, "/rst_stall"}, stall, 0);
            chk({tag, "/rst_valid"}, md_valid, 0);
            chk({tag, "/rst_result"}, md_result, 0);
            chk({tag, "/rst_decode"}, Operation, 4'b1111);
            last_res = '0;
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            chk({tag, "/idle_stall"}, stall, 0);
        end
        any = 0;
        repeat (40) begin
            @(negedge clk);
            if (md_valid) any = 1;
        end
        chk({tag, "/no_valid"}, any, 0);
        chk({tag, "/hold"}, md_result, last_res);
    endtask

    initial begin
        logic [3:0]  eop;
        logic        eill;
        logic [2:0]  rf3;
        logic [31:0] ra, rb;
        bit          any;
        rst_n = 1'b0; ALUOp = '0; Funct7 = '0; Funct3 = '0; in_valid = 1'b0; flush = 1'b0;
        rs1_data = '0; rs2_data = '0;
        #12;
        chk("reset/stall", stall, 0);
        chk("reset/md_valid", md_valid, 0);
        chk("reset/md_result", md_result, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full decode sweep with no instruction valid
        for (int aop = 0; aop < 4; aop++)
            for (int f3 = 0; f3 < 8; f3++)
                for (int f7 = 0; f7 < 128; f7++) begin
                    ALUOp = 2'(aop); Funct3 = 3'(f3); Funct7 = 7'(f7);
                    #1;
                    ref_dec(aop, f3, f7, eop, eill);
                    chk($sformatf("dec/%0d_%0d_%0d/op", aop, f3, f7), Operation, eop);
                    chk($sformatf("dec/%0d_%0d_%0d/ill", aop, f3, f7), illegal, eill);
                end

        // Directed arithmetic cases
        run_md(3'd0, 32'd7, 32'hFFFF_FFFD, 0, "mul_7x-3");
        run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "mulhu_max");
        run_md(3'd1, 32'hFFFF_FFF9, 32'd2, 0, "mulh_neg");
        run_md(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu");
        run_md(3'd4, 32'hFFFF_FFF9, 32'd2, 0, "div_-7_2");
        run_md(3'd6, 32'hFFFF_FFF9, 32'd2, 1, "rem_-7_2");
        run_md(3'd5, 32'd100, 32'd7, 0, "divu_100_7");
        run_md(3'd7, 32'd100, 32'd7, 0, "remu_100_7");
        run_md(3'd4, 32'd5, 32'd0, 0, "div_by0");
        run_md(3'd6, 32'd5, 32'd0, 0, "rem_by0");
        run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
        run_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");

        // Aborts
        abort_at10(0, "flush10");
        abort_at10(1, "reset10");

        // Flush takes priority over an acceptance in the same cycle
        @(negedge clk);
        ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = 3'd4; rs1_data = 32'd5; rs2_data = 32'd0;
        in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_accept/stall", stall, 0);
        any = 0;
        repeat (5) begin
            @(negedge clk);
            if (md_valid) any = 1;
        end
        chk("flush_accept/no_valid", any, 0);

        // Randomized ops, including zero divisors and the overflow pair
        for (int i = 0; i < 24; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: ra = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            run_md(rf3, ra, rb, bit'(i % 2), $sformatf("rand%0d_f%0d", i, rf3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
